// File: rtl/regfile_sb.sv
// Integer register file with write-back select mux, a second (long-latency) write port
// and a per-register busy scoreboard that gates instruction issue on pending writes.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rR1,
   input  logic [AW-1:0]   rR2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic [AW-1:0]   wR,
   input  logic            rf_we,
   input  logic [1:0]      wd_sel,
   input  logic [XLEN-1:0] wd_aluc,
   input  logic [XLEN-1:0] wd_dramrd,
   input  logic [XLEN-1:0] wd_npcpc4,
   input  logic [XLEN-1:0] wd_sextext,
   output logic [XLEN-1:0] wD,
   input  logic            issue_valid,
   input  logic            issue_long,
   output logic            issue_ready,
   input  logic            lw_valid,
   input  logic [AW-1:0]   lw_addr,
   input  logic [XLEN-1:0] lw_data,
   output logic [NREG-1:0] busy,
   output logic            sb_err
);

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] lw_hit;
   logic [NREG-1:0] effbusy;
   logic            issue_fire;
   logic            lw_err;

   // Register 0 and out-of-range addresses never report a pending write.
   function automatic logic busy_of(input logic [NREG-1:0] vec, input logic [AW-1:0] a);
      if (a == '0 || int'(a) >= NREG)
         return 1'b0;
      return vec[a];
   endfunction

   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
      if (a == '0 || int'(a) >= NREG)
         return '0;
      if (BYPASS != 0 && lw_valid && lw_addr == a)
         return lw_data;
      if (BYPASS != 0 && rf_we && wR == a)
         return wD;
      return rf[a];
   endfunction

   always_comb begin
      wD = wd_aluc;
      case (wd_sel)
         2'b00: wD = wd_aluc;
         2'b01: wD = wd_dramrd;
         2'b10: wD = wd_npcpc4;
         2'b11: wD = wd_sextext;
      endcase
   end

   // A long write completing this cycle already releases its register for issue.
   always_comb begin
      lw_hit = '0;
      for (int i = 0; i < NREG; i++)
         lw_hit[i] = lw_valid && (lw_addr == AW'(i));
      effbusy = busy & ~lw_hit;
   end

   always_comb begin
      issue_ready = ~(busy_of(effbusy, rR1) | busy_of(effbusy, rR2) | busy_of(effbusy, wR));
      issue_fire  = issue_valid && issue_ready && issue_long && (wR != '0);
      lw_err      = lw_valid && (lw_addr != '0) && !busy_of(busy, lw_addr);
   end

   always_comb begin
      rd1 = read_port(rR1);
      rd2 = read_port(rR2);
   end

   // Long path has priority over the short path; a fresh long issue beats a completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= '0;
         busy   <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (lw_hit[i])
               rf[i] <= lw_data;
            else if (rf_we && wR == AW'(i))
               rf[i] <= wD;

            if (issue_fire && wR == AW'(i))
               busy[i] <= 1'b1;
            else if (lw_hit[i])
               busy[i] <= 1'b0;
         end
         if (lw_err)
            sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based behavioural model.
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   rR1, rR2, wR, lw_addr;
   logic [XLEN-1:0] rd1, rd2, wD, lw_data;
   logic [XLEN-1:0] wd_aluc, wd_dramrd, wd_npcpc4, wd_sextext;
   logic [1:0]      wd_sel;
   logic            rf_we, issue_valid, issue_long, issue_ready, lw_valid, sb_err;
   logic [NREG-1:0] busy;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_rf [NREG];
   logic [NREG-1:0] m_busy;
   logic            m_err;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .rR1(rR1), .rR2(rR2), .rd1(rd1), .rd2(rd2),
      .wR(wR), .rf_we(rf_we), .wd_sel(wd_sel), .wd_aluc(wd_aluc),
      .wd_dramrd(wd_dramrd), .wd_npcpc4(wd_npcpc4), .wd_sextext(wd_sextext),
      .wD(wD), .issue_valid(issue_valid), .issue_long(issue_long),
      .issue_ready(issue_ready), .lw_valid(lw_valid), .lw_addr(lw_addr),
      .lw_data(lw_data), .busy(busy), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] exp_wd();
      case (wd_sel)
         2'd0:    return wd_aluc;
         2'd1:    return wd_dramrd;
         2'd2:    return wd_npcpc4;
         default: return wd_sextext;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (lw_valid && lw_addr == a) return lw_data;
      if (rf_we && wR == a) return exp_wd();
      return m_rf[a];
   endfunction

   function automatic logic pending(input logic [AW-1:0] a);
      return (a != 0) && m_busy[a] && !(lw_valid && lw_addr == a);
   endfunction

   function automatic logic exp_ready();
      return !(pending(rR1) || pending(rR2) || pending(wR));
   endfunction

   task automatic model_edge();
      logic fire;
      fire = issue_valid && exp_ready() && issue_long && wR != 0;
      if (lw_valid && lw_addr != 0 && !m_busy[lw_addr]) m_err = 1'b1;
      if (rf_we && wR != 0) m_rf[wR] = exp_wd();
      if (lw_valid && lw_addr != 0) m_rf[lw_addr] = lw_data;
      if (lw_valid) m_busy[lw_addr] = 1'b0;
      if (fire) m_busy[wR] = 1'b1;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rR1 = 0; rR2 = 0; wR = 0; rf_we = 0; wd_sel = 0;
      wd_aluc = 0; wd_dramrd = 0; wd_npcpc4 = 0; wd_sextext = 0;
      issue_valid = 0; issue_long = 0; lw_valid = 0; lw_addr = 0; lw_data = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
      m_busy = '0;
      m_err  = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int a = 0; a < NREG; a++) begin
         rR1 = AW'(a);
         rR2 = AW'(NREG - 1 - a);
         #1;
         checks++;
         if (rd1 !== '0 || rd2 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_read a=%0d: rd1=%h rd2=%h expected 0", a, rd1, rd2);
         end
         tick();
      end
      checks++;
      if (busy !== '0 || sb_err !== 1'b0 || issue_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_state: busy=%h sb_err=%b ready=%b expected 0/0/1",
                  busy, sb_err, issue_ready);
      end
   endtask

   task automatic test_bypass();
      wd_sel = 2'b11; wd_sextext = 32'h1234_5678; wd_aluc = 32'h1111_1111;
      rf_we = 1; wR = 5; rR1 = 5;
      #1;
      checks++;
      if (wD !== 32'h1234_5678 || rd1 !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL bypass_same_cycle: wD=%h rd1=%h expected 12345678", wD, rd1);
      end
      tick();
      rf_we = 0; wd_sextext = 0;
      #1;
      checks++;
      if (rd1 !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL write_x5: rd1=%h expected 12345678", rd1);
      end
      clear_inputs();
   endtask

   task automatic test_x0();
      rf_we = 1; wR = 0; wd_sel = 2'b00; wd_aluc = 32'hFFFF_FFFF; rR1 = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (rd1 !== '0) begin
            errors++;
            $display("[TB] FAIL x0_zero cycle=%0d: rd1=%h expected 0", c, rd1);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_long_hazard();
      issue_valid = 1; issue_long = 1; wR = 7;
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL issue_x7_ready: got %b expected 1", issue_ready);
      end
      tick();
      clear_inputs();
      rR2 = 7;
      #1;
      checks++;
      if (busy[7] !== 1'b1 || issue_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL raw_stall: busy7=%b ready=%b expected 1/0", busy[7], issue_ready);
      end
      lw_valid = 1; lw_addr = 7; lw_data = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (issue_ready !== 1'b1 || rd2 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL lw_complete: ready=%b rd2=%h expected 1/deadbeef", issue_ready, rd2);
      end
      tick();
      lw_valid = 0; lw_data = 0;
      #1;
      checks++;
      if (busy[7] !== 1'b0 || rd2 !== 32'hDEAD_BEEF || sb_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lw_retired: busy7=%b rd2=%h sb_err=%b expected 0/deadbeef/0",
                  busy[7], rd2, sb_err);
      end
      clear_inputs();
   endtask

   task automatic test_set_clear_same();
      issue_valid = 1; issue_long = 1; wR = 7;
      tick();
      lw_valid = 1; lw_addr = 7; lw_data = 32'hCAFE_0007;
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reissue_ready: got %b expected 1", issue_ready);
      end
      tick();
      clear_inputs();
      rR1 = 7;
      #1;
      checks++;
      if (busy[7] !== 1'b1 || rd1 !== 32'hCAFE_0007 || sb_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL set_wins: busy7=%b rd1=%h sb_err=%b expected 1/cafe0007/0",
                  busy[7], rd1, sb_err);
      end
      lw_valid = 1; lw_addr = 7; lw_data = 32'h0000_0777;
      tick();
      clear_inputs();
      rf_we = 1; wR = 3; wd_sel = 2'b01; wd_dramrd = 32'hAAAA_0003;
      issue_valid = 1; issue_long = 1;
      tick();
      clear_inputs();
      lw_valid = 1; lw_addr = 3; lw_data = 32'hBBBB_0003;
      rf_we = 1; wR = 3; wd_sel = 2'b10; wd_npcpc4 = 32'hCCCC_0003;
      tick();
      clear_inputs();
      rR1 = 3; rR2 = 7;
      #1;
      checks++;
      if (rd1 !== 32'hBBBB_0003 || rd2 !== 32'h0000_0777 || busy !== '0) begin
         errors++;
         $display("[TB] FAIL long_wins: rd1=%h rd2=%h busy=%h expected bbbb0003/00000777/0",
                  rd1, rd2, busy);
      end
   endtask

   task automatic test_sb_err_reset();
      lw_valid = 1; lw_addr = 9; lw_data = 32'h9999_0009;
      tick();
      clear_inputs();
      rR1 = 9;
      #1;
      checks++;
      if (sb_err !== 1'b1 || rd1 !== 32'h9999_0009) begin
         errors++;
         $display("[TB] FAIL sb_err_set: sb_err=%b rd1=%h expected 1/99990009", sb_err, rd1);
      end
      issue_valid = 1; issue_long = 1; wR = 4;
      tick();
      clear_inputs();
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (sb_err !== 1'b0 || busy !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset: sb_err=%b busy=%h expected 0/0", sb_err, busy);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
      m_busy = '0;
      m_err  = 1'b0;
      lw_valid = 1; lw_addr = 4; lw_data = 32'h4444_0004;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (sb_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stale_lw_err: sb_err=%b expected 1", sb_err);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rR1 = AW'($urandom_range(0, 9));
         rR2 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 9));
         wR  = AW'($urandom_range(0, 9));
         rf_we = $urandom_range(0, 1) == 1;
         wd_sel = 2'($urandom);
         wd_aluc = $urandom; wd_dramrd = $urandom; wd_npcpc4 = $urandom; wd_sextext = $urandom;
         issue_valid = $urandom_range(0, 2) != 0;
         issue_long  = $urandom_range(0, 1) == 1;
         a = AW'($urandom_range(0, 9));
         lw_valid = m_busy[a] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
         lw_addr = a;
         lw_data = $urandom;
         #1;
         checks++;
         if (rd1 !== exp_rd(rR1) || rd2 !== exp_rd(rR2) || wD !== exp_wd()) begin
            errors++;
            $display("[TB] FAIL rand_read c=%0d: rd1=%h/%h rd2=%h/%h wD=%h/%h (got/expected)",
                     c, rd1, exp_rd(rR1), rd2, exp_rd(rR2), wD, exp_wd());
         end
         checks++;
         if (issue_ready !== exp_ready() || busy !== m_busy || sb_err !== m_err) begin
            errors++;
            $display("[TB] FAIL rand_sb c=%0d: ready=%b/%b busy=%h/%h sb_err=%b/%b (got/expected)",
                     c, issue_ready, exp_ready(), busy, m_busy, sb_err, m_err);
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_bypass();
      test_x0();
      test_long_hazard();
      test_set_clear_same();
      test_sb_err_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
